// File: rtl/regfile_wp_arbiter.sv
// Write-port owner and arbiter for the 32x32 register file: WB has priority,
// MDU uses valid/ready with a starvation stall. Optional scrub: RF_SCRUB_EN.
module regfile_wp_arbiter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned R_WIDTH      = 5,
  parameter int unsigned REGSIZE      = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pipe_we_i,
  input  logic [R_WIDTH-1:0] pipe_waddr_i,
  input  logic [WIDTH-1:0]   pipe_wdata_i,
  input  logic               mdu_valid_i,
  input  logic [R_WIDTH-1:0] mdu_waddr_i,
  input  logic [WIDTH-1:0]   mdu_wdata_i,
  output logic               mdu_ready_o,
  output logic               rf_we_o,
  output logic [R_WIDTH-1:0] rf_waddr_o,
  output logic [WIDTH-1:0]   rf_wdata_o,
  output logic               stall_o,
  output logic               init_busy_o
);

  if (STARVE_LIMIT < 1 ||
      STARVE_LIMIT > (1 << CNT_W) - 1 ||
      REGSIZE > (1 << R_WIDTH)) begin : g_cfg_err
    $error("regfile_wp_arbiter: bad parameters");
  end

  logic               w_scrub;
  logic [R_WIDTH-1:0] w_scrub_addr;
  logic               w_pipe_sel;
  logic               w_xfer;
  logic               w_blocked;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic               r_stall;

`ifdef RF_SCRUB_EN
  typedef enum logic {
    S_SCRUB,
    S_ARB
  } state_t;

  localparam logic [R_WIDTH-1:0] LP_LAST = R_WIDTH'(REGSIZE - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [R_WIDTH-1:0] r_scrub_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_SCRUB;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_SCRUB: begin
        if (r_scrub_cnt == LP_LAST) begin
          w_state_nxt = S_ARB;
        end
      end
      S_ARB:   w_state_nxt = S_ARB;
      default: w_state_nxt = S_ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scrub_cnt <= '0;
    end else if (r_state == S_SCRUB) begin
      r_scrub_cnt <= r_scrub_cnt + 1'b1;
    end
  end

  assign w_scrub      = (r_state == S_SCRUB);
  assign w_scrub_addr = r_scrub_cnt;
`else
  assign w_scrub      = 1'b0;
  assign w_scrub_addr = '0;
`endif

  assign w_pipe_sel = ~w_scrub & pipe_we_i;

  // Address 0 never commits in ARB, but the MDU handshake still completes.
  always_comb begin
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    mdu_ready_o = 1'b0;
    init_busy_o = 1'b0;
    unique case (1'b1)
      w_scrub: begin
        rf_we_o     = 1'b1;
        rf_waddr_o  = w_scrub_addr;
        init_busy_o = 1'b1;
      end
      w_pipe_sel: begin
        rf_we_o    = |pipe_waddr_i;
        rf_waddr_o = pipe_waddr_i;
        rf_wdata_o = pipe_wdata_i;
      end
      default: begin
        mdu_ready_o = 1'b1;
        if (mdu_valid_i) begin
          rf_we_o    = |mdu_waddr_i;
          rf_waddr_o = mdu_waddr_i;
          rf_wdata_o = mdu_wdata_i;
        end
      end
    endcase
  end

  assign w_xfer    = mdu_valid_i & mdu_ready_o;
  assign w_blocked = ~w_scrub & mdu_valid_i & ~mdu_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      if (w_xfer || !mdu_valid_i) begin
        r_starve_cnt <= '0;
      end else if (w_blocked &&
                   r_starve_cnt != CNT_W'(STARVE_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
      if (w_xfer) begin
        r_stall <= 1'b0;
      end else if (w_blocked &&
                   r_starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
        r_stall <= 1'b1;
      end
    end
  end

  assign stall_o = r_stall;

endmodule

// File: tb/tb_regfile_wp_arbiter.sv
// Scoreboard bench for regfile_wp_arbiter: directed vectors push expected
// port values, a negedge monitor pops and compares them.
module tb_regfile_wp_arbiter;

  logic        clk_i;
  logic        rst_n_i;
  logic        pipe_we_i;
  logic [4:0]  pipe_waddr_i;
  logic [31:0] pipe_wdata_i;
  logic        mdu_valid_i;
  logic [4:0]  mdu_waddr_i;
  logic [31:0] mdu_wdata_i;
  logic        mdu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        stall_o;
  logic        init_busy_o;

  regfile_wp_arbiter dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .pipe_we_i    (pipe_we_i),
    .pipe_waddr_i (pipe_waddr_i),
    .pipe_wdata_i (pipe_wdata_i),
    .mdu_valid_i  (mdu_valid_i),
    .mdu_waddr_i  (mdu_waddr_i),
    .mdu_wdata_i  (mdu_wdata_i),
    .mdu_ready_o  (mdu_ready_o),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .stall_o      (stall_o),
    .init_busy_o  (init_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        rdy;
    logic        st;
    logic        busy;
    logic        cd;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic expect_now(input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic rdy,
                            input logic st, input logic busy,
                            input logic cd, input string nm);
    exp_t e;
    e.we = we; e.a = a; e.d = d; e.rdy = rdy;
    e.st = st; e.busy = busy; e.cd = cd; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa,
                       input logic [31:0] pd, input logic mv,
                       input logic [4:0] ma, input logic [31:0] md);
    pipe_we_i = pwe; pipe_waddr_i = pa; pipe_wdata_i = pd;
    mdu_valid_i = mv; mdu_waddr_i = ma; mdu_wdata_i = md;
  endtask

  task automatic step(input logic pwe, input logic [4:0] pa,
                      input logic [31:0] pd, input logic mv,
                      input logic [4:0] ma, input logic [31:0] md,
                      input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic rdy,
                      input logic st, input logic busy,
                      input logic cd, input string nm);
    @(posedge clk_i);
    #1;
    drive(pwe, pa, pd, mv, ma, md);
    expect_now(we, a, d, rdy, st, busy, cd, nm);
  endtask

  task automatic idle(input logic st, input string nm);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, st, 0, 1, nm);
  endtask

  always @(negedge clk_i) begin
    if (q.size() != 0) begin
      m_e = q.pop_front();
      n_chk++;
      if (rf_we_o !== m_e.we || rf_waddr_o !== m_e.a ||
          (m_e.cd && rf_wdata_o !== m_e.d) ||
          mdu_ready_o !== m_e.rdy || stall_o !== m_e.st ||
          init_busy_o !== m_e.busy) begin
        n_fail++;
        $display("FAIL %s: got we=%0b a=%0d d=%h rdy=%0b st=%0b busy=%0b, required we=%0b a=%0d d=%h rdy=%0b st=%0b busy=%0b",
                 m_e.nm, rf_we_o, rf_waddr_o, rf_wdata_o, mdu_ready_o,
                 stall_o, init_busy_o, m_e.we, m_e.a, m_e.d, m_e.rdy,
                 m_e.st, m_e.busy);
      end
    end
  end

  initial begin
    rst_n_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
`ifdef RF_SCRUB_EN
    expect_now(1, 0, 0, 0, 0, 1, 1, "reset");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    expect_now(1, 0, 0, 0, 0, 1, 1, "scrub_0");
    for (int k = 1; k < 32; k++)
      step(0, 0, 0, 0, 0, 0, 1, 5'(k), 0, 0, 0, 1, 1, "scrub");
    idle(0, "scrub_done");
`else
    expect_now(0, 0, 0, 1, 0, 0, 1, "reset");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    expect_now(0, 0, 0, 1, 0, 0, 1, "post_reset_idle");
`endif

    step(1, 5, 32'hDEADBEEF, 0, 0, 0,
         1, 5, 32'hDEADBEEF, 0, 0, 0, 1, "pipe_only");
    idle(0, "idle");

    step(1, 3, 32'h3333_3333, 1, 9, 32'h9999_0009,
         1, 3, 32'h3333_3333, 0, 0, 0, 1, "collide_pipe");
    step(0, 0, 0, 1, 9, 32'h9999_0009,
         1, 9, 32'h9999_0009, 1, 0, 0, 1, "collide_mdu");
    idle(0, "collide_idle");

    for (int i = 0; i < 6; i++)
      step(1, 7, 32'hA000_0000 + 32'(i), 1, 12, 32'hCAFEF00D,
           1, 7, 32'hA000_0000 + 32'(i), 0, (i >= 4), 0, 1,
           (i >= 4) ? "starve_stall" : "starve_blocked");
    step(0, 0, 0, 1, 12, 32'hCAFEF00D,
         1, 12, 32'hCAFEF00D, 1, 1, 0, 1, "starve_xfer");
    idle(0, "stall_clear");

    for (int i = 0; i < 4; i++)
      step(1, 8, 32'hB000_0000 + 32'(i), 1, 13, 32'h0000_0D0D,
           1, 8, 32'hB000_0000 + 32'(i), 0, 0, 0, 1, "recount");
    step(0, 0, 0, 1, 13, 32'h0000_0D0D,
         1, 13, 32'h0000_0D0D, 1, 1, 0, 1, "recount_xfer");
    idle(0, "recount_clear");

    step(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0, "r0_mdu");
    step(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "r0_pipe");
    idle(0, "r0_idle");

`ifdef RF_SCRUB_EN
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    expect_now(1, 0, 0, 0, 0, 1, 1, "rescrub_reset");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    expect_now(1, 0, 0, 0, 0, 1, 1, "rescrub_0");
    for (int k = 1; k <= 10; k++)
      step(0, 0, 0, 0, 0, 0, 1, 5'(k), 0, 0, 0, 1, 1, "rescrub");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    expect_now(1, 0, 0, 0, 0, 1, 1, "mid_scrub_reset");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    expect_now(1, 0, 0, 0, 0, 1, 1, "restart_0");
    for (int k = 1; k < 4; k++)
      step(0, 0, 0, 0, 0, 0, 1, 5'(k), 0, 0, 0, 1, 1, "restart");
`else
    for (int i = 0; i < 5; i++)
      step(1, 4, 32'hC0, 1, 14, 32'hE0,
           1, 4, 32'hC0, 0, (i == 4), 0, 1, "pre_reset_block");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    expect_now(0, 0, 0, 1, 0, 0, 1, "reset_mid_stall");
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    expect_now(0, 0, 0, 1, 0, 0, 1, "post_reset2");
    for (int i = 0; i < 4; i++)
      step(1, 4, 32'hC1, 1, 14, 32'hE1,
           1, 4, 32'hC1, 0, 0, 0, 1, "post_reset_block");
    step(0, 0, 0, 1, 14, 32'hE1, 1, 14, 32'hE1, 1, 1, 0, 1,
         "post_reset_xfer");
    idle(0, "post_reset_clear");
`endif

    repeat (3) @(posedge clk_i);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
